axi_tb_slave_mem: RTL and testbench

AXI_TB_SLAVE_MEM -- requirements
Module: axi_tb_slave_mem

---
 rtl/axi_tb_slave_mem.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_tb_slave_mem.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tb_slave_mem.sv
// ----------------------------------------------------------------------------
// axi_tb_slave_mem
// AXI4 slave memory model with an independent write FSM and read FSM.
// The memory holds MEM_DEPTH words of DATA_WIDTH bits. Word 0 sits at byte
// address BASE_ADDR. Only INCR bursts modify memory. Out-of-range beats report
// DECERR, and wlast misuse or a non-INCR burst reports SLVERR. The memory
// contents survive reset.
//
// Ports
//   ACLK, ARESETN             clock (rising edge), synchronous active-low reset
//   S_AXI_aw*                 write address channel (addr, len, burst, handshake)
//   S_AXI_w*                  write data channel (data, strobes, last, handshake)
//   S_AXI_b*                  write response channel
//   S_AXI_ar*                 read address channel (addr, len, handshake)
//   S_AXI_r*                  read data channel (data, resp, last, handshake)
// ----------------------------------------------------------------------------
module axi_tb_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_awaddr,
    input  logic [7:0]                S_AXI_awlen,
    input  logic [1:0]                S_AXI_awburst,
    input  logic                      S_AXI_awvalid,
    output logic                      S_AXI_awready,
    input  logic [DATA_WIDTH-1:0]     S_AXI_wdata,
    input  logic [DATA_WIDTH/8-1:0]   S_AXI_wstrb,
    input  logic                      S_AXI_wlast,
    input  logic                      S_AXI_wvalid,
    output logic                      S_AXI_wready,
    output logic [1:0]                S_AXI_bresp,
    output logic                      S_AXI_bvalid,
    input  logic                      S_AXI_bready,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_araddr,
    input  logic [7:0]                S_AXI_arlen,
    input  logic                      S_AXI_arvalid,
    output logic                      S_AXI_arready,
    output logic [DATA_WIDTH-1:0]     S_AXI_rdata,
    output logic [1:0]                S_AXI_rresp,
    output logic                      S_AXI_rlast,
    output logic                      S_AXI_rvalid,
    input  logic                      S_AXI_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Full-width word index. The range check looks at every bit, so an
    // address past the end never aliases onto a low word.
    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
        return (a - BASE_ADDR) >> SHIFT;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t              w_state_reg;
    logic [ADDR_WIDTH-1:0] w_addr_reg;
    logic [7:0]            w_len_reg;
    logic [7:0]            w_beat_reg;
    logic [1:0]            w_burst_reg;
    logic                  w_decerr_reg;
    logic                  w_proterr_reg;
    logic [1:0]            bresp_reg;

    logic [ADDR_WIDTH-1:0] w_word;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_in_range;
    logic                  w_hs;
    logic                  w_last_beat;
    logic                  w_beat_proterr;
    logic                  w_incr;
    logic                  mem_we;
    logic                  w_decerr_next;
    logic                  w_proterr_next;

    assign w_word         = word_index(w_addr_reg);
    assign w_idx          = w_word[IDX_W-1:0];
    assign w_in_range     = (w_addr_reg >= BASE_ADDR) && (w_word < DEPTH_A);
    assign w_hs           = (w_state_reg == W_DATA) && S_AXI_wvalid;
    assign w_last_beat    = (w_beat_reg == w_len_reg);
    assign w_beat_proterr = (S_AXI_wlast != w_last_beat);
    assign w_incr         = (w_burst_reg == BURST_INCR);
    // A beat that coincides with a reset edge is dropped with the burst.
    assign mem_we         = w_hs && w_in_range && w_incr && ARESETN;
    // Error flags including the beat being accepted, for the final response.
    assign w_decerr_next  = w_decerr_reg  | ~w_in_range;
    assign w_proterr_next = w_proterr_reg | w_beat_proterr;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state_reg   <= W_IDLE;
            bresp_reg     <= RESP_OKAY;
            w_decerr_reg  <= 1'b0;
            w_proterr_reg <= 1'b0;
            w_beat_reg    <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (S_AXI_awvalid) begin
                        w_addr_reg    <= S_AXI_awaddr;
                        w_len_reg     <= S_AXI_awlen;
                        w_burst_reg   <= S_AXI_awburst;
                        w_beat_reg    <= '0;
                        w_decerr_reg  <= 1'b0;
                        w_proterr_reg <= 1'b0;
                        w_state_reg   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (S_AXI_wvalid) begin
                        w_addr_reg    <= w_addr_reg + STEP;
                        w_beat_reg    <= w_beat_reg + 8'd1;
                        w_decerr_reg  <= w_decerr_next;
                        w_proterr_reg <= w_proterr_next;
                        // The beat count alone ends the burst; wlast only
                        // feeds the protocol-error flag.
                        if (w_last_beat) begin
                            w_state_reg <= W_RESP;
                            if (w_decerr_next)
                                bresp_reg <= RESP_DECERR;
                            else if (!w_incr || w_proterr_next)
                                bresp_reg <= RESP_SLVERR;
                            else
                                bresp_reg <= RESP_OKAY;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_bready)
                        w_state_reg <= W_IDLE;
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // Byte-lane write port. No reset: contents outlive ARESETN.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_wstrb[b])
                    mem[w_idx][b*8 +: 8] <= S_AXI_wdata[b*8 +: 8];
            end
        end
    end

    assign S_AXI_awready = (w_state_reg == W_IDLE);
    assign S_AXI_wready  = (w_state_reg == W_DATA);
    assign S_AXI_bvalid  = (w_state_reg == W_RESP);
    assign S_AXI_bresp   = bresp_reg;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    r_state_t              r_state_reg;
    logic [ADDR_WIDTH-1:0] r_addr_reg;   // address of the next beat to load
    logic [7:0]            r_len_reg;
    logic [7:0]            r_beat_reg;   // beat currently presented
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;
    logic                  rlast_reg;
    logic                  rvalid_reg;

    logic                  r_load;
    logic [ADDR_WIDTH-1:0] r_src_addr;
    logic [ADDR_WIDTH-1:0] r_word;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_in_range;
    logic [7:0]            r_beat_next;
    logic [7:0]            r_len_next;

    // A beat is loaded on the AR handshake, or on an R handshake that is not
    // the last one, so back-to-back beats have no bubble.
    assign r_load      = ((r_state_reg == R_IDLE) && S_AXI_arvalid) ||
                         ((r_state_reg == R_DATA) && S_AXI_rready && !rlast_reg);
    assign r_src_addr  = (r_state_reg == R_IDLE) ? S_AXI_araddr : r_addr_reg;
    assign r_word      = word_index(r_src_addr);
    assign r_idx       = r_word[IDX_W-1:0];
    assign r_in_range  = (r_src_addr >= BASE_ADDR) && (r_word < DEPTH_A);
    assign r_beat_next = (r_state_reg == R_IDLE) ? 8'd0 : r_beat_reg + 8'd1;
    assign r_len_next  = (r_state_reg == R_IDLE) ? S_AXI_arlen : r_len_reg;

    // Reading mem with a non-blocking register returns the pre-write value
    // when a W beat targets the same word on the same edge.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state_reg <= R_IDLE;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
        end else if (r_load) begin
            rdata_reg   <= r_in_range ? mem[r_idx] : '0;
            rresp_reg   <= r_in_range ? RESP_OKAY : RESP_DECERR;
            rlast_reg   <= (r_beat_next == r_len_next);
            rvalid_reg  <= 1'b1;
            r_state_reg <= R_DATA;
            r_addr_reg  <= r_src_addr + STEP;
            r_beat_reg  <= r_beat_next;
            r_len_reg   <= r_len_next;
        end else if ((r_state_reg == R_DATA) && S_AXI_rready) begin
            // Last beat accepted.
            r_state_reg <= R_IDLE;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
        end
    end

    assign S_AXI_arready = (r_state_reg == R_IDLE);
    assign S_AXI_rvalid  = rvalid_reg;
    assign S_AXI_rdata   = rdata_reg;
    assign S_AXI_rresp   = rresp_reg;
    assign S_AXI_rlast   = rlast_reg;

endmodule

// File: tb/tb_axi_tb_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_axi_tb_slave_mem
// Scoreboard bench for axi_tb_slave_mem with default parameters. Expected
// write responses and read beats come from a reference memory and are pushed
// to queues when a burst is issued. They are popped when the DUT completes
// the matching handshake. Inputs change 1 ns after the rising edge, and
// outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_axi_tb_slave_mem;

    localparam int DEPTH = 1024;

    logic        ACLK;
    logic        ARESETN;
    logic [31:0] S_AXI_awaddr;
    logic [7:0]  S_AXI_awlen;
    logic [1:0]  S_AXI_awburst;
    logic        S_AXI_awvalid;
    logic        S_AXI_awready;
    logic [31:0] S_AXI_wdata;
    logic [3:0]  S_AXI_wstrb;
    logic        S_AXI_wlast;
    logic        S_AXI_wvalid;
    logic        S_AXI_wready;
    logic [1:0]  S_AXI_bresp;
    logic        S_AXI_bvalid;
    logic        S_AXI_bready;
    logic [31:0] S_AXI_araddr;
    logic [7:0]  S_AXI_arlen;
    logic        S_AXI_arvalid;
    logic        S_AXI_arready;
    logic [31:0] S_AXI_rdata;
    logic [1:0]  S_AXI_rresp;
    logic        S_AXI_rlast;
    logic        S_AXI_rvalid;
    logic        S_AXI_rready;

    axi_tb_slave_mem dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_awaddr  (S_AXI_awaddr),
        .S_AXI_awlen   (S_AXI_awlen),
        .S_AXI_awburst (S_AXI_awburst),
        .S_AXI_awvalid (S_AXI_awvalid),
        .S_AXI_awready (S_AXI_awready),
        .S_AXI_wdata   (S_AXI_wdata),
        .S_AXI_wstrb   (S_AXI_wstrb),
        .S_AXI_wlast   (S_AXI_wlast),
        .S_AXI_wvalid  (S_AXI_wvalid),
        .S_AXI_wready  (S_AXI_wready),
        .S_AXI_bresp   (S_AXI_bresp),
        .S_AXI_bvalid  (S_AXI_bvalid),
        .S_AXI_bready  (S_AXI_bready),
        .S_AXI_araddr  (S_AXI_araddr),
        .S_AXI_arlen   (S_AXI_arlen),
        .S_AXI_arvalid (S_AXI_arvalid),
        .S_AXI_arready (S_AXI_arready),
        .S_AXI_rdata   (S_AXI_rdata),
        .S_AXI_rresp   (S_AXI_rresp),
        .S_AXI_rlast   (S_AXI_rlast),
        .S_AXI_rvalid  (S_AXI_rvalid),
        .S_AXI_rready  (S_AXI_rready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } rexp_t;

    rexp_t       rq[$];
    logic [1:0]  bq[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] wd [8];
    logic [3:0]  ws [8];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >> 2) < 32'(DEPTH);
    endfunction

    // flip_beat: beat whose wlast is inverted (-1 none). bready_hold: cycles
    // bready stays low once bvalid rises. abort_after: beat after which reset
    // is pulsed instead of finishing (-1 none).
    task automatic write_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                               input int flip_beat, input int bready_hold, input int abort_after);
        logic [1:0]  exp_resp;
        logic [1:0]  got_resp;
        logic        dec;
        logic        prot;
        logic [31:0] a;
        int          cyc;
        dec  = 1'b0;
        prot = (flip_beat >= 0) && (flip_beat <= len);
        a    = addr;
        for (int i = 0; i <= len; i++) begin
            if (!in_rng(a)) dec = 1'b1;
            a = a + 32'd4;
        end
        exp_resp = dec ? 2'b11 : ((burst != 2'b01 || prot) ? 2'b10 : 2'b00);
        if (abort_after < 0) bq.push_back(exp_resp);

        @(posedge ACLK); #1;
        S_AXI_awaddr  = addr;
        S_AXI_awlen   = 8'(len);
        S_AXI_awburst = burst;
        S_AXI_awvalid = 1'b1;
        S_AXI_bready  = (bready_hold == 0);
        cyc = 0;
        @(negedge ACLK);
        while (!S_AXI_awready && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        check("awready", S_AXI_awready, 1);
        @(posedge ACLK); #1;
        S_AXI_awvalid = 1'b0;

        a = addr;
        for (int i = 0; i <= len; i++) begin
            S_AXI_wdata  = wd[i];
            S_AXI_wstrb  = ws[i];
            S_AXI_wlast  = (i == len) ^ (i == flip_beat);
            S_AXI_wvalid = 1'b1;
            @(negedge ACLK);
            check("wready", S_AXI_wready, 1);
            if (burst == 2'b01 && in_rng(a)) begin
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model_mem[int'(a >> 2)][b*8 +: 8] = wd[i][b*8 +: 8];
            end
            a = a + 32'd4;
            @(posedge ACLK); #1;
            if (i == abort_after) begin
                ARESETN      = 1'b0;
                S_AXI_wvalid = 1'b0;
                S_AXI_wlast  = 1'b0;
                @(posedge ACLK); #1;
                ARESETN = 1'b1;
                @(negedge ACLK);
                check("abort_awready", S_AXI_awready, 1);
                check("abort_bvalid", S_AXI_bvalid, 0);
                $display("WR addr=0x%08h len=%0d aborted after beat %0d", addr, len, i);
                return;
            end
        end
        S_AXI_wvalid = 1'b0;
        S_AXI_wlast  = 1'b0;

        @(negedge ACLK);
        check("bvalid_lat", S_AXI_bvalid, 1);
        for (int h = 0; h < bready_hold; h++) begin
            if (h > 0) @(negedge ACLK);
            check("bvalid_hold", S_AXI_bvalid, 1);
            check("bresp_hold", S_AXI_bresp, exp_resp);
        end
        if (bready_hold > 0) begin
            @(posedge ACLK); #1;
            S_AXI_bready = 1'b1;
            @(negedge ACLK);
            check("bvalid_hs", S_AXI_bvalid, 1);
        end
        got_resp = S_AXI_bresp;
        check("bresp", got_resp, bq.pop_front());
        @(posedge ACLK); #1;
        S_AXI_bready = 1'b0;
        @(negedge ACLK);
        check("bvalid_drop", S_AXI_bvalid, 0);
        $display("WR addr=0x%08h len=%0d burst=%0b bresp=%0b", addr, len, burst, got_resp);
    endtask

    // pat[k] is rready for cycle k after the AR handshake; 1 beyond pat_len.
    task automatic read_burst(input logic [31:0] addr, input int len,
                              input logic [15:0] pat, input int pat_len);
        logic [31:0] a;
        rexp_t       e;
        int          beats;
        int          k;
        int          cyc;
        bit          stall;
        logic [31:0] sd;
        logic [1:0]  sr;
        logic        sl;
        a = addr;
        for (int i = 0; i <= len; i++) begin
            if (in_rng(a)) rq.push_back('{d: model_mem[int'(a >> 2)], r: 2'b00, l: (i == len)});
            else           rq.push_back('{d: 32'h0, r: 2'b11, l: (i == len)});
            a = a + 32'd4;
        end

        @(posedge ACLK); #1;
        S_AXI_araddr  = addr;
        S_AXI_arlen   = 8'(len);
        S_AXI_arvalid = 1'b1;
        S_AXI_rready  = 1'b0;
        cyc = 0;
        @(negedge ACLK);
        while (!S_AXI_arready && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        check("arready", S_AXI_arready, 1);
        @(posedge ACLK); #1;
        S_AXI_arvalid = 1'b0;

        beats = 0;
        stall = 0;
        k     = 0;
        sd = '0; sr = '0; sl = 1'b0;
        S_AXI_rready = (k < pat_len) ? pat[k] : 1'b1;
        @(negedge ACLK);
        check("rvalid_lat", S_AXI_rvalid, 1);
        for (cyc = 0; cyc < 64; cyc++) begin
            if (S_AXI_rvalid) begin
                if (stall) begin
                    check("rdata_stable", S_AXI_rdata, sd);
                    check("rresp_stable", S_AXI_rresp, sr);
                    check("rlast_stable", S_AXI_rlast, sl);
                end
                if (S_AXI_rready) begin
                    e = rq.pop_front();
                    check("rdata", S_AXI_rdata, e.d);
                    check("rresp", S_AXI_rresp, e.r);
                    check("rlast", S_AXI_rlast, e.l);
                    beats++;
                    stall = 0;
                end else begin
                    stall = 1;
                    sd = S_AXI_rdata; sr = S_AXI_rresp; sl = S_AXI_rlast;
                end
            end
            if (beats == len + 1) break;
            @(posedge ACLK); #1;
            k++;
            S_AXI_rready = (k < pat_len) ? pat[k] : 1'b1;
            @(negedge ACLK);
        end
        check("r_beats", beats, len + 1);
        @(posedge ACLK); #1;
        S_AXI_rready = 1'b0;
        @(negedge ACLK);
        check("rvalid_drop", S_AXI_rvalid, 0);
        $display("RD addr=0x%08h len=%0d beats=%0d", addr, len, beats);
        rq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN = 1'b0;
        S_AXI_awaddr = '0; S_AXI_awlen = '0; S_AXI_awburst = 2'b01; S_AXI_awvalid = 1'b0;
        S_AXI_wdata = '0; S_AXI_wstrb = '0; S_AXI_wlast = 1'b0; S_AXI_wvalid = 1'b0;
        S_AXI_bready = 1'b0;
        S_AXI_araddr = '0; S_AXI_arlen = '0; S_AXI_arvalid = 1'b0; S_AXI_rready = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_awready", S_AXI_awready, 1);
        check("rst_arready", S_AXI_arready, 1);
        check("rst_wready", S_AXI_wready, 0);
        check("rst_bvalid", S_AXI_bvalid, 0);
        check("rst_rvalid", S_AXI_rvalid, 0);
        check("rst_rlast", S_AXI_rlast, 0);
        check("rst_bresp", S_AXI_bresp, 0);
        check("rst_rresp", S_AXI_rresp, 0);
        check("rst_rdata", S_AXI_rdata, 0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;

        // Single write and read-back.
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        write_burst(32'h10, 0, 2'b01, -1, 0, -1);
        read_burst(32'h10, 0, 16'h1, 1);

        // Clear, then strobed INCR burst; read back under rready backpressure.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h0; ws[i] = 4'hF; end
        write_burst(32'h100, 3, 2'b01, -1, 0, -1);
        wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
        ws[0] = 4'hF;  ws[1] = 4'hF;  ws[2] = 4'h3;  ws[3] = 4'hC;
        write_burst(32'h100, 3, 2'b01, -1, 0, -1);
        read_burst(32'h100, 3, 16'b1011001, 7);

        // Out of range: word 0 must not be hit by aliasing.
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        write_burst(32'h0, 0, 2'b01, -1, 0, -1);
        wd[0] = 32'hCAFEF00D;
        write_burst(32'h1000, 0, 2'b01, -1, 0, -1);
        read_burst(32'h1000, 0, 16'h1, 1);
        read_burst(32'h0, 0, 16'h1, 1);

        // Non-INCR burst writes nothing.
        wd[0] = 32'hA0A0A0A0; wd[1] = 32'hB1B1B1B1; ws[0] = 4'hF; ws[1] = 4'hF;
        write_burst(32'h200, 1, 2'b01, -1, 0, -1);
        wd[0] = 32'h55555555; wd[1] = 32'h66666666;
        write_burst(32'h200, 1, 2'b00, -1, 0, -1);
        read_burst(32'h200, 1, 16'h3, 2);

        // Early wlast, with bready held low for 5 cycles.
        wd[0] = 32'h77770001; wd[1] = 32'h77770002;
        write_burst(32'h300, 1, 2'b01, 0, 5, -1);
        read_burst(32'h300, 1, 16'h3, 2);

        // Burst crossing the end of memory: first beat lands, second is DECERR.
        wd[0] = 32'h0E0D0C0B; wd[1] = 32'h99999999;
        write_burst(32'hFFC, 1, 2'b01, -1, 0, -1);
        read_burst(32'hFFC, 1, 16'h3, 2);

        // Reset mid-burst, then recover.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hAAAA0000 + 32'(i); ws[i] = 4'hF; end
        write_burst(32'h400, 3, 2'b01, -1, 0, -1);
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        write_burst(32'h400, 3, 2'b01, -1, 0, 1);
        read_burst(32'h400, 3, 16'hF, 4);
        wd[0] = 32'h5A5A5A5A; ws[0] = 4'hF;
        write_burst(32'h500, 0, 2'b01, -1, 0, -1);
        read_burst(32'h500, 0, 16'h1, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
